// File: rtl/nmi_pkg.sv
// Shared NMI types and constants for the native memory interface arbiter.
package nmi_pkg;

   localparam int NMI_ADDR_W = 32;
   localparam int NMI_DATA_W = 32;
   localparam int NMI_STRB_W = 4;

   localparam logic [NMI_DATA_W-1:0] NMI_TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      GAP
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant_i wins,
// wrapping around, with last_grant_i itself lowest priority.
module rr_arbiter #(
   parameter int NUM_MSTR = 4
) (
   input  logic [NUM_MSTR-1:0]         req_i,
   input  logic [$clog2(NUM_MSTR)-1:0] last_grant_i,
   output logic [$clog2(NUM_MSTR)-1:0] grant_o,
   output logic                        any_req_o
);

   localparam int IDX_W = $clog2(NUM_MSTR);

   logic [IDX_W-1:0] candIdx;
   int               slot;

   // Walk from the farthest offset back to the nearest so the nearest requester wins.
   always_comb begin
      grant_o   = '0;
      any_req_o = |req_i;
      candIdx   = '0;
      slot      = 0;
      for (int i = NUM_MSTR; i >= 1; i--) begin
         slot = int'(last_grant_i) + i;
         if (slot >= NUM_MSTR) begin
            slot = slot - NUM_MSTR;
         end
         candIdx = IDX_W'(slot);
         if (req_i[candIdx]) begin
            grant_o = candIdx;
         end
      end
   end

endmodule

// File: rtl/nmi_arbiter.sv
// N-to-1 NMI initiator arbiter with round-robin grant held until slave ready.
// Optional watchdog enabled by defining NMI_ARB_TIMEOUT_EN (adds timeout_o).
module nmi_arbiter
   import nmi_pkg::*;
#(
   parameter int NUM_MSTR    = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_MSTR-1:0]            mstr_valid_i,
   input  logic [NUM_MSTR*NMI_ADDR_W-1:0] mstr_addr_i,
   input  logic [NUM_MSTR*NMI_DATA_W-1:0] mstr_wdata_i,
   input  logic [NUM_MSTR*NMI_STRB_W-1:0] mstr_wstrb_i,
   output logic [NMI_DATA_W-1:0]          mstr_rdata_o,
   output logic [NUM_MSTR-1:0]            mstr_ready_o,
   output logic                           slv_valid_o,
   output logic [NMI_ADDR_W-1:0]          slv_addr_o,
   output logic [NMI_DATA_W-1:0]          slv_wdata_o,
   output logic [NMI_STRB_W-1:0]          slv_wstrb_o,
   input  logic [NMI_DATA_W-1:0]          slv_rdata_i,
   input  logic                           slv_ready_i,
   output logic [$clog2(NUM_MSTR)-1:0]    grant_o,
   output logic                           busy_o
`ifdef NMI_ARB_TIMEOUT_EN
   ,
   output logic                           timeout_o
`endif
);

   localparam int IDX_W = $clog2(NUM_MSTR);

   if (NUM_MSTR < 2 || NUM_MSTR > 8 || TIMEOUT_CYC < 2) begin : g_bad_params
      $error("nmi_arbiter: NUM_MSTR must be 2..8 and TIMEOUT_CYC at least 2");
   end

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] lastGrant_q, lastGrant_d;
   logic [IDX_W-1:0] rrGrant;
   logic             anyReq;

   logic [NMI_ADDR_W-1:0] mstrAddr  [NUM_MSTR];
   logic [NMI_DATA_W-1:0] mstrWdata [NUM_MSTR];
   logic [NMI_STRB_W-1:0] mstrWstrb [NUM_MSTR];

`ifdef NMI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   assign timeout_o = timeout_q;
`endif

   rr_arbiter #(
      .NUM_MSTR (NUM_MSTR)
   ) u_rr (
      .req_i        (mstr_valid_i),
      .last_grant_i (lastGrant_q),
      .grant_o      (rrGrant),
      .any_req_o    (anyReq)
   );

   always_comb begin
      for (int k = 0; k < NUM_MSTR; k++) begin
         mstrAddr[k]  = mstr_addr_i[k*NMI_ADDR_W +: NMI_ADDR_W];
         mstrWdata[k] = mstr_wdata_i[k*NMI_DATA_W +: NMI_DATA_W];
         mstrWstrb[k] = mstr_wstrb_i[k*NMI_STRB_W +: NMI_STRB_W];
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q == BUSY);

   // The granted master's valid alone decides between completion and abort;
   // a ready seen while that valid is low does not count.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      lastGrant_d  = lastGrant_q;
      slv_valid_o  = 1'b0;
      slv_addr_o   = '0;
      slv_wdata_o  = '0;
      slv_wstrb_o  = '0;
      mstr_ready_o = '0;
      mstr_rdata_o = '0;
`ifdef NMI_ARB_TIMEOUT_EN
      cnt_d        = '0;
      timeout_d    = timeout_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (anyReq) begin
               grant_d = rrGrant;
               state_d = BUSY;
            end
         end
         BUSY: begin
            slv_valid_o = mstr_valid_i[grant_q];
            slv_addr_o  = mstrAddr[grant_q];
            slv_wdata_o = mstrWdata[grant_q];
            slv_wstrb_o = mstrWstrb[grant_q];
`ifdef NMI_ARB_TIMEOUT_EN
            cnt_d       = cnt_q + CNT_W'(1);
`endif
            if (mstr_valid_i[grant_q] && slv_ready_i) begin
               mstr_ready_o[grant_q] = 1'b1;
               mstr_rdata_o          = slv_rdata_i;
               lastGrant_d           = grant_q;
               state_d               = GAP;
            end else if (!mstr_valid_i[grant_q]) begin
               lastGrant_d = grant_q;
               state_d     = IDLE;
`ifdef NMI_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               slv_valid_o           = 1'b0;
               mstr_ready_o[grant_q] = 1'b1;
               mstr_rdata_o          = NMI_TIMEOUT_RDATA;
               timeout_d             = 1'b1;
               lastGrant_d           = grant_q;
               state_d               = GAP;
`endif
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Last grant resets to the top index so master 0 wins the first arbitration.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         lastGrant_q <= IDX_W'(NUM_MSTR - 1);
`ifdef NMI_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
`ifdef NMI_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Directed self-checking bench for nmi_arbiter with four masters.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_nmi_arbiter;

   localparam int NM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NM-1:0] mstrValid = '0;
   logic [NM*32-1:0] mstrAddr = '0;
   logic [NM*32-1:0] mstrWdata = '0;
   logic [NM*4-1:0]  mstrWstrb = '0;
   logic [31:0]   mstrRdata;
   logic [NM-1:0] mstrReady;
   logic          slvValid;
   logic [31:0]   slvAddr;
   logic [31:0]   slvWdata;
   logic [3:0]    slvWstrb;
   logic [31:0]   slvRdata = '0;
   logic          slvReady = 1'b0;
   logic [1:0]    grant;
   logic          busy;
`ifdef NMI_ARB_TIMEOUT_EN
   logic          timeout;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nmi_arbiter #(
      .NUM_MSTR    (NM),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mstr_valid_i (mstrValid),
      .mstr_addr_i  (mstrAddr),
      .mstr_wdata_i (mstrWdata),
      .mstr_wstrb_i (mstrWstrb),
      .mstr_rdata_o (mstrRdata),
      .mstr_ready_o (mstrReady),
      .slv_valid_o  (slvValid),
      .slv_addr_o   (slvAddr),
      .slv_wdata_o  (slvWdata),
      .slv_wstrb_o  (slvWstrb),
      .slv_rdata_i  (slvRdata),
      .slv_ready_i  (slvReady),
      .grant_o      (grant),
      .busy_o       (busy)
`ifdef NMI_ARB_TIMEOUT_EN
      ,
      .timeout_o    (timeout)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setMaster(input int k, input logic v, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      mstrValid[k]        = v;
      mstrAddr[32*k +: 32] = a;
      mstrWdata[32*k +: 32] = d;
      mstrWstrb[4*k +: 4]  = s;
   endtask

   // Leaves the bench 1ns into the first IDLE cycle with reset released.
   task automatic doReset();
      rst = 1'b1;
      mstrValid = '0;
      mstrAddr = '0;
      mstrWdata = '0;
      mstrWstrb = '0;
      slvReady = 1'b0;
      slvRdata = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++; if (slvValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_slv_valid: got %b want 0", slvValid); end
      checks++; if (mstrReady !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0000", mstrReady); end
      checks++; if (mstrRdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", mstrRdata); end
      checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant: got %0d want 0", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({slvAddr, slvWdata, slvWstrb} !== 68'h0) begin errors++; $display("[TB] FAIL reset_slv_bus: got %h want 0", {slvAddr, slvWdata, slvWstrb}); end
   endtask

   task automatic test_single_read();
      doReset();
      setMaster(2, 1'b1, 32'h1000_1004, 32'h0, 4'b0000);
      @(negedge clk);
      checks++; if (slvValid !== 1'b0) begin errors++; $display("[TB] FAIL read_idle_valid: got %b want 0", slvValid); end
      tick();
      slvRdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if (slvValid !== 1'b1) begin errors++; $display("[TB] FAIL read_valid_t1: got %b want 1", slvValid); end
      checks++; if (slvAddr !== 32'h1000_1004) begin errors++; $display("[TB] FAIL read_addr: got %h want 10001004", slvAddr); end
      checks++; if (grant !== 2'd2) begin errors++; $display("[TB] FAIL read_grant: got %0d want 2", grant); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy: got %b want 1", busy); end
      checks++; if (mstrReady !== 4'b0000) begin errors++; $display("[TB] FAIL read_early_ready: got %b want 0000", mstrReady); end
      checks++; if (mstrRdata !== 32'h0) begin errors++; $display("[TB] FAIL read_rdata_unqualified: got %h want 0", mstrRdata); end
      tick();
      slvReady = 1'b1;
      slvRdata = 32'h1234_5678;
      @(negedge clk);
      checks++; if (mstrReady !== 4'b0100) begin errors++; $display("[TB] FAIL read_ready: got %b want 0100", mstrReady); end
      checks++; if (mstrRdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL read_rdata: got %h want 12345678", mstrRdata); end
      tick();
      slvReady = 1'b0;
      slvRdata = '0;
      setMaster(2, 1'b0, 32'h0, 32'h0, 4'b0000);
      @(negedge clk);
      checks++; if ({slvValid, busy, mstrReady} !== 6'b0) begin errors++; $display("[TB] FAIL read_gap: got valid=%b busy=%b ready=%b want all 0", slvValid, busy, mstrReady); end
      checks++; if (slvAddr !== 32'h0) begin errors++; $display("[TB] FAIL read_gap_addr: got %h want 0", slvAddr); end
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_back_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_round_robin();
      logic [1:0] expG;
      doReset();
      for (int k = 0; k < NM; k++) begin
         setMaster(k, 1'b1, 32'h4000_0000 + 32'(k) * 32'h100, 32'h0, 4'b0000);
      end
      for (int n = 0; n < 6; n++) begin
         expG = 2'(n % NM);
         @(negedge clk);
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle_busy[%0d]: got %b want 0", n, busy); end
         tick();
         @(negedge clk);
         checks++; if (grant !== expG) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %0d want %0d", n, grant, expG); end
         checks++; if (slvAddr !== 32'h4000_0000 + 32'(expG) * 32'h100) begin errors++; $display("[TB] FAIL rr_addr[%0d]: got %h want %h", n, slvAddr, 32'h4000_0000 + 32'(expG) * 32'h100); end
         tick();
         slvReady = 1'b1;
         slvRdata = 32'hC0DE_0000 + 32'(n);
         @(negedge clk);
         checks++; if (mstrReady !== (4'b0001 << expG)) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", n, mstrReady, 4'b0001 << expG); end
         checks++; if (mstrRdata !== 32'hC0DE_0000 + 32'(n)) begin errors++; $display("[TB] FAIL rr_rdata[%0d]: got %h want %h", n, mstrRdata, 32'hC0DE_0000 + 32'(n)); end
         tick();
         slvReady = 1'b0;
         @(negedge clk);
         checks++; if ({busy, slvValid, mstrReady} !== 6'b0) begin errors++; $display("[TB] FAIL rr_gap[%0d]: got busy=%b valid=%b ready=%b want all 0", n, busy, slvValid, mstrReady); end
         tick();
      end
   endtask

   task automatic test_write_mux();
      doReset();
      setMaster(1, 1'b1, 32'h2000_0010, 32'hA5A5_0000, 4'b0011);
      setMaster(3, 1'b1, 32'h3000_0000, 32'h1111_2222, 4'b1111);
      tick();
      slvReady = 1'b1;
      @(negedge clk);
      checks++; if (grant !== 2'd1) begin errors++; $display("[TB] FAIL wr_grant1: got %0d want 1", grant); end
      checks++; if ({slvAddr, slvWdata, slvWstrb} !== {32'h2000_0010, 32'hA5A5_0000, 4'b0011}) begin errors++; $display("[TB] FAIL wr_bus1: got %h %h %b want 20000010 a5a50000 0011", slvAddr, slvWdata, slvWstrb); end
      checks++; if (mstrReady !== 4'b0010) begin errors++; $display("[TB] FAIL wr_ready1: got %b want 0010", mstrReady); end
      tick();
      slvReady = 1'b0;
      setMaster(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      @(negedge clk);
      checks++; if (slvWstrb !== 4'b0000) begin errors++; $display("[TB] FAIL wr_gap_strb: got %b want 0000", slvWstrb); end
      tick();
      tick();
      slvReady = 1'b1;
      @(negedge clk);
      checks++; if (grant !== 2'd3) begin errors++; $display("[TB] FAIL wr_grant3: got %0d want 3", grant); end
      checks++; if ({slvWdata, slvWstrb} !== {32'h1111_2222, 4'b1111}) begin errors++; $display("[TB] FAIL wr_bus3: got %h %b want 11112222 1111", slvWdata, slvWstrb); end
      checks++; if (mstrReady !== 4'b1000) begin errors++; $display("[TB] FAIL wr_ready3: got %b want 1000", mstrReady); end
      tick();
      slvReady = 1'b0;
      mstrValid = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      doReset();
      setMaster(2, 1'b1, 32'h5000_0000, 32'h0, 4'b0000);
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'd2) begin errors++; $display("[TB] FAIL rmid_grant2: got %0d want 2", grant); end
      tick();
      rst = 1'b1;
      setMaster(0, 1'b1, 32'h5000_1000, 32'h0, 4'b0000);
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({slvValid, mstrReady, busy} !== 6'b0) begin errors++; $display("[TB] FAIL rmid_after_reset: got valid=%b ready=%b busy=%b want all 0", slvValid, mstrReady, busy); end
      checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL rmid_grant_reset: got %0d want 0", grant); end
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_first_grant: got grant=%0d busy=%b want 0 1", grant, busy); end
      checks++; if (slvAddr !== 32'h5000_1000) begin errors++; $display("[TB] FAIL rmid_addr: got %h want 50001000", slvAddr); end
   endtask

   task automatic test_abort();
      doReset();
      setMaster(3, 1'b1, 32'h6000_0000, 32'h0, 4'b0000);
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'd3) begin errors++; $display("[TB] FAIL abort_grant3: got %0d want 3", grant); end
      tick();
      setMaster(3, 1'b0, 32'h0, 32'h0, 4'b0000);
      slvReady = 1'b1;
      @(negedge clk);
      checks++; if (slvValid !== 1'b0 || mstrReady !== 4'b0000) begin errors++; $display("[TB] FAIL abort_drop: got valid=%b ready=%b want 0 0000", slvValid, mstrReady); end
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b0 || mstrReady !== 4'b0000) begin errors++; $display("[TB] FAIL abort_idle: got busy=%b ready=%b want 0 0000", busy, mstrReady); end
      slvReady = 1'b0;
      tick();
      setMaster(0, 1'b1, 32'h6000_0100, 32'h0, 4'b0000);
      setMaster(3, 1'b1, 32'h6000_0000, 32'h0, 4'b0000);
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL abort_next_grant: got %0d want 0", grant); end
      tick();
      mstrValid = '0;
      tick();
      setMaster(0, 1'b1, 32'h6000_0100, 32'h0, 4'b0000);
      setMaster(1, 1'b1, 32'h6000_0200, 32'h0, 4'b0000);
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'd1) begin errors++; $display("[TB] FAIL abort_last_grant_update: got %0d want 1", grant); end
      tick();
      mstrValid = '0;
      tick();
   endtask

`ifdef NMI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int earlyBad;
      earlyBad = 0;
      doReset();
      setMaster(1, 1'b1, 32'h7000_0000, 32'h0, 4'b0000);
      tick();
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (mstrReady !== 4'b0000 || slvValid !== 1'b1 || timeout !== 1'b0) earlyBad++;
         tick();
      end
      checks++; if (earlyBad !== 0) begin errors++; $display("[TB] FAIL to_early: got %0d bad cycles want 0", earlyBad); end
      @(negedge clk);
      checks++; if (mstrReady !== 4'b0010) begin errors++; $display("[TB] FAIL to_ready: got %b want 0010", mstrReady); end
      checks++; if (mstrRdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL to_rdata: got %h want deadbeef", mstrRdata); end
      checks++; if (slvValid !== 1'b0) begin errors++; $display("[TB] FAIL to_valid_drop: got %b want 0", slvValid); end
      tick();
      mstrValid = '0;
      tick();
      tick();
      tick();
      @(negedge clk);
      checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky: got %b want 1", timeout); end
      doReset();
      @(negedge clk);
      checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_cleared: got %b want 0", timeout); end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_mux();
      test_reset_mid();
      test_abort();
`ifdef NMI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
